// File: rtl/frame_reader.sv
// Wishbone burst read master: streams the SDRAM framebuffer into the display pixel FIFO.
// Bursts are gated by FIFO almost-full in IDLE; the pointer wraps at frame end or on restart.
module frame_reader #(
  parameter int          HDISP    = 800,
  parameter int          VDISP    = 480,
  parameter int          BURST    = 64,
  parameter logic [31:0] BASE_ADR = 32'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] wshb_adr,
  output logic        wshb_cyc,
  output logic        wshb_stb,
  output logic        wshb_we,
  output logic [3:0]  wshb_sel,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  input  logic [31:0] wshb_dat_sm,
  input  logic        wshb_ack,
  input  logic        fifo_afull,
  output logic        fifo_we,
  output logic [24:0] fifo_wdata,
  input  logic        restart
);

  localparam int NPIX   = HDISP * VDISP;
  localparam int PIX_W  = $clog2(NPIX);
  localparam int BEAT_W = $clog2(BURST);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_adr;
  logic [PIX_W-1:0]   r_pix_cnt;
  logic [BEAT_W-1:0]  r_beat_cnt;
  logic               r_restart_pend;
  logic               r_fifo_we;
  logic [24:0]        r_fifo_wdata;

  logic w_beat;
  logic w_last;
  logic w_frame_end;
  logic w_clr_ptr;

  assign w_beat      = (r_state == S_BURST) && wshb_ack;
  assign w_frame_end = (r_pix_cnt == PIX_W'(NPIX - 1));
  assign w_last      = (r_beat_cnt == BEAT_W'(BURST - 1)) || w_frame_end;

  // Outside a burst a restart clears the pointer at once; inside, only on the final ack,
  // where a frame wrap and a restart collapse into the same single clear.
  assign w_clr_ptr = (r_state != S_BURST) ? (restart || r_restart_pend)
                   : (w_beat && w_last && (w_frame_end || restart || r_restart_pend));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!fifo_afull) w_state_nxt = S_BURST;
      S_BURST: if (w_beat && w_last) w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adr          <= BASE_ADR;
      r_pix_cnt      <= '0;
      r_beat_cnt     <= '0;
      r_restart_pend <= 1'b0;
      r_fifo_we      <= 1'b0;
      r_fifo_wdata   <= '0;
    end else begin
      r_fifo_we      <= w_beat;
      r_restart_pend <= (r_state == S_BURST) && !(w_beat && w_last) &&
                        (restart || r_restart_pend);
      if (w_beat)
        r_fifo_wdata <= {(r_pix_cnt == '0), wshb_dat_sm[23:0]};
      if (w_clr_ptr) begin
        r_adr      <= BASE_ADR;
        r_pix_cnt  <= '0;
        r_beat_cnt <= '0;
      end else if (w_beat) begin
        r_adr      <= r_adr + 32'd4;
        r_pix_cnt  <= r_pix_cnt + PIX_W'(1);
        r_beat_cnt <= w_last ? '0 : r_beat_cnt + BEAT_W'(1);
      end
    end
  end

  assign wshb_stb   = (r_state == S_BURST);
  assign wshb_cyc   = wshb_stb;
  assign wshb_adr   = r_adr;
  assign wshb_cti   = (r_state != S_BURST) ? 3'b000 : (w_last ? 3'b111 : 3'b010);
  assign wshb_we    = 1'b0;
  assign wshb_sel   = 4'b1111;
  assign wshb_bte   = 2'b00;
  assign fifo_we    = r_fifo_we;
  assign fifo_wdata = r_fifo_wdata;

endmodule
